// File: rtl/icap_pkg.sv
// Shared definitions for the ICAP configuration sequencer: FSM state
// encodings and error code values reported to the register block.
`timescale 1ns/1ps
package icap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DRAIN  = 2'b10,
        ERROR  = 2'b11
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;

endpackage

// File: rtl/icap_bit_swap.sv
// Per-byte bit reversal for ICAP data. ICAP expects each byte bit-reversed
// relative to the bitstream file order; the same block serves readback.
`timescale 1ns/1ps
module icap_bit_swap #(
    parameter int DATA_WIDTH = 32,
    parameter bit SWAP_BITS  = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] swapped
);

    // Reverse bits inside each byte, or pass through when swapping is off.
    always_comb begin
        swapped = data;
        if (SWAP_BITS) begin
            for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                for (int j = 0; j < 8; j++) begin
                    swapped[8*k + j] = data[8*k + 7 - j];
                end
            end
        end
    end

endmodule

// File: rtl/icap_config_sequencer.sv
// ICAP write-port sequencer: accepts the 32-bit configuration stream,
// drives CSIB/RDWRB/I, stalls on BUSY, guards blocks with an inactivity
// watchdog and software abort, and keeps done/error/word-count status.
`timescale 1ns/1ps
module icap_config_sequencer
    import icap_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter bit SWAP_BITS      = 1'b1,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DRAIN_CYCLES   = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  blk_start,
    input  logic                  blk_end,
    input  logic                  cfg_end,
    input  logic                  enable,
    input  logic                  abort,
    input  logic                  clr_stat,
    input  logic                  icap_busy,
    output logic                  icap_csib,
    output logic                  icap_rdwrb,
    output logic [DATA_WIDTH-1:0] icap_i,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_error,
    output logic [1:0]            err_code,
    output logic [31:0]           word_count
);

    state_t                state;
    state_t                state_nxt;
    logic [15:0]           wdog;
    logic [15:0]           drain_cnt;
    logic                  save_cfg_end;
    logic                  err_pend;
    logic                  accept;
    logic                  timeout_hit;
    logic                  drain_last;
    logic                  err_set;
    logic [1:0]            err_nxt;
    logic [DATA_WIDTH-1:0] swap_data;

    icap_bit_swap #(
        .DATA_WIDTH (DATA_WIDTH),
        .SWAP_BITS  (SWAP_BITS)
    ) u_swap (
        .data    (s_data),
        .swapped (swap_data)
    );

    // In ERROR the stream is drained and discarded so the converter never backs up.
    assign s_ready     = ((state == ACTIVE) & ~icap_busy) | (state == ERROR);
    assign accept      = s_valid & s_ready & (state == ACTIVE);
    assign busy        = (state != IDLE);
    // A cycle with a transfer is not idle, so it can never be the timeout cycle.
    assign timeout_hit = (wdog == 16'(TIMEOUT_CYCLES - 1)) & ~accept;
    assign drain_last  = (drain_cnt == 16'(DRAIN_CYCLES - 1));

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort/disable outranks timeout, which outranks blk_end.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_nxt   = ERR_NONE;
        case (state)
            IDLE: begin
                if (blk_start && enable) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (abort || !enable) begin
                    state_nxt = ERROR;
                    err_set   = 1'b1;
                    err_nxt   = ERR_ABORT;
                end else if (timeout_hit) begin
                    state_nxt = ERROR;
                    err_set   = 1'b1;
                    err_nxt   = ERR_TIMEOUT;
                end else if (blk_end) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) state_nxt = IDLE;
            end
            ERROR: begin
                if (blk_end || err_pend) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ICAP pins: one-cycle registered write per accepted word; RDWRB only moves with CSIB high.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b1;
            icap_i     <= '0;
        end else begin
            icap_csib <= ~accept;
            if (accept) icap_i <= swap_data;
            if (state == IDLE && state_nxt == ACTIVE)
                icap_rdwrb <= 1'b0;
            else if ((state == DRAIN || state == ERROR) && state_nxt == IDLE)
                icap_rdwrb <= 1'b1;
        end
    end

    // Watchdog, drain counter and block-scoped flags.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wdog         <= '0;
            drain_cnt    <= '0;
            save_cfg_end <= 1'b0;
            err_pend     <= 1'b0;
        end else begin
            if (state != ACTIVE || accept) wdog <= '0;
            else if (wdog != 16'hFFFF)     wdog <= wdog + 16'd1;

            if (state == DRAIN) drain_cnt <= drain_cnt + 16'd1;
            else                drain_cnt <= '0;

            if (state == ACTIVE && cfg_end)       save_cfg_end <= 1'b1;
            else if (state == DRAIN && drain_last) save_cfg_end <= 1'b0;
            else if (state == IDLE || state == ERROR) save_cfg_end <= 1'b0;

            // Remember a blk_end that arrived together with the error cause.
            err_pend <= (state == ACTIVE) & err_set & blk_end;
        end
    end

    // Sticky status; a same-cycle set takes priority over clr_stat.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
            err_code   <= ERR_NONE;
            word_count <= '0;
        end else begin
            if (clr_stat) begin
                cfg_done  <= 1'b0;
                cfg_error <= 1'b0;
                err_code  <= ERR_NONE;
            end
            if (state == DRAIN && drain_last && save_cfg_end) cfg_done <= 1'b1;
            if (err_set) begin
                cfg_error <= 1'b1;
                if (err_code == ERR_NONE || clr_stat) err_code <= err_nxt;
            end
            if (clr_stat)    word_count <= accept ? 32'd1 : 32'd0;
            else if (accept) word_count <= word_count + 32'd1;
        end
    end

endmodule
